// File: rtl/srcnn_mac_accum_pkg.sv
// Shared definitions for the SRCNN accumulation/activation datapath:
// default widths, accumulator FSM states and the accumulator width check.
package srcnn_pkg;

    localparam int unsigned PROD_WIDTH_DEF = 69;
    localparam int unsigned OUT_WIDTH_DEF  = 32;
    localparam int unsigned SHIFT_DEF      = 16;
    localparam int unsigned TAPS_DEF       = 81;
    localparam int unsigned ACC_WIDTH_DEF  = 79;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r = 0;
        int unsigned x = 1;
        while (x < v) begin
            x = x << 1;
            r++;
        end
        return r;
    endfunction

    // The accumulator must hold TAPS full-scale products without wrapping.
    function automatic bit acc_width_ok(input int unsigned acc_w,
                                        input int unsigned prod_w,
                                        input int unsigned taps);
        return (taps >= 1) && (taps <= 1024) && (acc_w >= prod_w + clog2(taps));
    endfunction

endpackage

// File: rtl/srcnn_mac_accum_if.sv
// Product-in / result-out stream bundle between the multiplier, the
// accumulator and the activation/write-back stage.
interface srcnn_mac_accum_if
    import srcnn_pkg::*;
#(
    parameter int unsigned PROD_WIDTH = PROD_WIDTH_DEF,
    parameter int unsigned OUT_WIDTH  = OUT_WIDTH_DEF
) ();

    logic [PROD_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  clear;
    logic [OUT_WIDTH-1:0]  out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sat;

    modport master (
        output in_data, in_valid, clear, out_ready,
        input  in_ready, out_data, out_valid, out_sat
    );

    modport slave (
        input  in_data, in_valid, clear, out_ready,
        output in_ready, out_data, out_valid, out_sat
    );

endinterface

// File: rtl/srcnn_mac_accum_sat_shift.sv
// Combinational logical right shift followed by unsigned saturation to
// OUT_WIDTH; also used by the bias/activation stage.
module srcnn_sat_shift
    import srcnn_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int unsigned OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int unsigned SHIFT     = SHIFT_DEF
) (
    input  logic [ACC_WIDTH-1:0] sum_i,
    output logic [OUT_WIDTH-1:0] data_o,
    output logic                 ovf_o
);

    logic [ACC_WIDTH-1:0] shifted;

    assign shifted = sum_i >> SHIFT;

    if (ACC_WIDTH > OUT_WIDTH) begin : g_narrow
        assign ovf_o  = |shifted[ACC_WIDTH-1:OUT_WIDTH];
        assign data_o = ovf_o ? '1 : shifted[OUT_WIDTH-1:0];
    end else begin : g_wide
        assign ovf_o  = 1'b0;
        assign data_o = OUT_WIDTH'(shifted);
    end

endmodule

// File: rtl/srcnn_mac_accum.sv
// Sums TAPS consecutive unsigned products per window, then emits the
// shifted, saturated sum through a registered valid/ready output.
module srcnn_mac_accum
    import srcnn_pkg::*;
#(
    parameter int unsigned PROD_WIDTH = PROD_WIDTH_DEF,
    parameter int unsigned TAPS       = TAPS_DEF,
    parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int unsigned SHIFT      = SHIFT_DEF,
    parameter int unsigned OUT_WIDTH  = OUT_WIDTH_DEF
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    srcnn_mac_accum_if.slave bus
);

    if (!acc_width_ok(ACC_WIDTH, PROD_WIDTH, TAPS)) begin : g_acc_width_chk
        $error("srcnn_mac_accum: TAPS out of range or ACC_WIDTH too small");
    end

    localparam int unsigned       CNT_W    = (TAPS > 1) ? clog2(TAPS) : 1;
    localparam logic [CNT_W-1:0]  LAST_TAP = CNT_W'(TAPS - 1);

    acc_state_t           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d, sum;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d, sat_data;
    logic                 out_valid_q, out_valid_d;
    logic                 out_sat_q, out_sat_d;
    logic                 sat_ovf;
    logic                 in_ready;
    logic                 accept;
    logic                 last;

    assign accept = bus.in_valid && in_ready;
    assign last   = (cnt_q == LAST_TAP);
    assign sum    = acc_q + ACC_WIDTH'(bus.in_data);

    srcnn_sat_shift #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_sat_shift (
        .sum_i  (sum),
        .data_o (sat_data),
        .ovf_o  (sat_ovf)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM:   if (accept && last) state_d = HOLD;
                HOLD:    if (bus.out_ready)  state_d = ACCUM;
                default: state_d = ACCUM;
            endcase
        end
    end

    always_comb begin
        in_ready = (state_q == ACCUM);
    end

    // clear wins over accept, so a product offered alongside clear is dropped.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sat_d   = out_sat_q;
        if (bus.clear) begin
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            out_sat_d   = 1'b0;
        end else if (accept) begin
            if (last) begin
                acc_d       = '0;
                cnt_d       = '0;
                out_data_d  = sat_data;
                out_sat_d   = sat_ovf;
                out_valid_d = 1'b1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if ((state_q == HOLD) && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_srcnn_mac_accum.sv
// Bench for srcnn_mac_accum with TAPS=4, SHIFT=2, OUT_WIDTH=8: vector table,
// hand sequences for backpressure/clear/reset, then random traffic vs a model.
module tb_srcnn_mac_accum;

    localparam int unsigned PW    = 69;
    localparam int unsigned OW    = 8;
    localparam int unsigned TAPS  = 4;
    localparam int unsigned SHIFT = 2;
    localparam int unsigned NVEC  = 18;

    logic ap_clk;
    logic ap_rst_n;
    int   errors = 0;
    int   checks = 0;

    srcnn_mac_accum_if #(.PROD_WIDTH(PW), .OUT_WIDTH(OW)) bus ();

    srcnn_mac_accum #(
        .PROD_WIDTH (PW),
        .TAPS       (TAPS),
        .ACC_WIDTH  (79),
        .SHIFT      (SHIFT),
        .OUT_WIDTH  (OW)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus.slave)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic          iv;
        logic [PW-1:0] d;
        logic          ordy;
        logic          e_ir;
        logic          e_ov;
        logic [OW-1:0] e_od;
        logic          e_sat;
    } vec_t;

    vec_t vt [NVEC];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [PW-1:0] d, input logic clr, input logic ordy);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.clear     = clr;
        bus.out_ready = ordy;
    endtask

    task automatic send_window(input logic [PW-1:0] d, input logic ordy);
        for (int i = 0; i < int'(TAPS); i++) begin
            drive(1'b1, d, 1'b0, ordy);
            tick();
        end
        drive(1'b0, '0, 1'b0, ordy);
    endtask

    task automatic chk_result(input string name, input logic [OW-1:0] od, input logic sat);
        chk({name, "_out_valid"}, 128'(bus.out_valid), 128'(1'b1));
        chk({name, "_out_data"},  128'(bus.out_data),  128'(od));
        chk({name, "_out_sat"},   128'(bus.out_sat),   128'(sat));
        chk({name, "_in_ready"},  128'(bus.in_ready),  128'(1'b0));
    endtask

    task automatic chk_idle_after_reset(input string name);
        chk({name, "_out_valid"}, 128'(bus.out_valid), 128'(1'b0));
        chk({name, "_out_data"},  128'(bus.out_data),  128'(0));
        chk({name, "_out_sat"},   128'(bus.out_sat),   128'(1'b0));
        chk({name, "_in_ready"},  128'(bus.in_ready),  128'(1'b1));
    endtask

    // Reference model state: products of the open window and the pending result.
    logic [PW-1:0]  win[$];
    logic           pend;
    logic [OW-1:0]  pend_data;
    logic           pend_sat;
    logic [127:0]   wsum;
    logic [127:0]   wshift;
    logic [95:0]    rbits;
    logic           r_iv, r_clr, r_ordy;
    logic [PW-1:0]  r_d;
    int unsigned    sel;

    initial begin
        vt[0]  = '{1'b1, 69'd4,   1'b1, 1'b1, 1'b0, 8'd0,   1'b0};
        vt[1]  = '{1'b1, 69'd8,   1'b1, 1'b1, 1'b0, 8'd0,   1'b0};
        vt[2]  = '{1'b1, 69'd12,  1'b1, 1'b1, 1'b0, 8'd0,   1'b0};
        vt[3]  = '{1'b1, 69'd16,  1'b1, 1'b0, 1'b1, 8'd10,  1'b0};
        vt[4]  = '{1'b0, 69'd0,   1'b1, 1'b1, 1'b0, 8'd0,   1'b0};
        vt[5]  = '{1'b1, 69'd400, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0};
        vt[6]  = '{1'b1, 69'd400, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0};
        vt[7]  = '{1'b1, 69'd400, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0};
        vt[8]  = '{1'b1, 69'd400, 1'b1, 1'b0, 1'b1, 8'd255, 1'b1};
        vt[9]  = '{1'b1, 69'd999, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0};
        vt[10] = '{1'b1, 69'd1,   1'b1, 1'b1, 1'b0, 8'd0,   1'b0};
        vt[11] = '{1'b0, 69'd77,  1'b1, 1'b1, 1'b0, 8'd0,   1'b0};
        vt[12] = '{1'b1, 69'd2,   1'b1, 1'b1, 1'b0, 8'd0,   1'b0};
        vt[13] = '{1'b0, 69'd77,  1'b1, 1'b1, 1'b0, 8'd0,   1'b0};
        vt[14] = '{1'b1, 69'd3,   1'b1, 1'b1, 1'b0, 8'd0,   1'b0};
        vt[15] = '{1'b0, 69'd77,  1'b1, 1'b1, 1'b0, 8'd0,   1'b0};
        vt[16] = '{1'b1, 69'd4,   1'b1, 1'b0, 1'b1, 8'd2,   1'b0};
        vt[17] = '{1'b0, 69'd0,   1'b1, 1'b1, 1'b0, 8'd0,   1'b0};

        ap_rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge ap_clk);
        #1;
        chk_idle_after_reset("reset");
        #2 ap_rst_n = 1'b1;
        tick();

        // Basic window, saturation, transfer dropped in HOLD, gapped input.
        for (int i = 0; i < int'(NVEC); i++) begin
            drive(vt[i].iv, vt[i].d, 1'b0, vt[i].ordy);
            tick();
            chk($sformatf("vec%0d_in_ready", i), 128'(bus.in_ready), 128'(vt[i].e_ir));
            chk($sformatf("vec%0d_out_valid", i), 128'(bus.out_valid), 128'(vt[i].e_ov));
            if (vt[i].e_ov) begin
                chk($sformatf("vec%0d_out_data", i), 128'(bus.out_data), 128'(vt[i].e_od));
                chk($sformatf("vec%0d_out_sat", i), 128'(bus.out_sat), 128'(vt[i].e_sat));
            end
        end

        // Backpressure: result held for 5 cycles while products are offered.
        send_window(69'd5, 1'b0);
        chk_result("bp_first", 8'd5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 69'd9, 1'b0, 1'b0);
            tick();
            chk_result($sformatf("bp_hold%0d", i), 8'd5, 1'b0);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        chk("bp_release_out_valid", 128'(bus.out_valid), 128'(1'b0));
        chk("bp_release_in_ready",  128'(bus.in_ready),  128'(1'b1));

        // Clear mid-window drops the partial sum and the concurrent product.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 69'd100, 1'b0, 1'b1);
            tick();
        end
        drive(1'b1, 69'd100, 1'b1, 1'b1);
        tick();
        chk("clr_mid_out_valid", 128'(bus.out_valid), 128'(1'b0));
        chk("clr_mid_in_ready",  128'(bus.in_ready),  128'(1'b1));
        send_window(69'd4, 1'b1);
        chk_result("clr_mid_next", 8'd4, 1'b0);
        tick();

        // Clear in HOLD discards the pending saturated result.
        send_window(69'd400, 1'b0);
        chk_result("clr_hold_pre", 8'd255, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        chk("clr_hold_out_valid", 128'(bus.out_valid), 128'(1'b0));
        chk("clr_hold_out_sat",   128'(bus.out_sat),   128'(1'b0));
        chk("clr_hold_in_ready",  128'(bus.in_ready),  128'(1'b1));
        send_window(69'd8, 1'b1);
        chk_result("clr_hold_next", 8'd8, 1'b0);
        tick();

        // Asynchronous reset mid-window.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 69'd100, 1'b0, 1'b1);
            tick();
        end
        #2 ap_rst_n = 1'b0;
        #1;
        chk_idle_after_reset("arst_window");
        drive(1'b0, '0, 1'b0, 1'b1);
        #2 ap_rst_n = 1'b1;
        tick();
        send_window(69'd8, 1'b1);
        chk_result("arst_window_next", 8'd8, 1'b0);
        tick();

        // Asynchronous reset while holding a result.
        send_window(69'd400, 1'b0);
        chk_result("arst_hold_pre", 8'd255, 1'b1);
        #2 ap_rst_n = 1'b0;
        #1;
        chk_idle_after_reset("arst_hold");
        drive(1'b0, '0, 1'b0, 1'b1);
        #2 ap_rst_n = 1'b1;
        tick();
        for (int i = 1; i <= int'(TAPS); i++) begin
            drive(1'b1, PW'(4 * i), 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        chk_result("arst_hold_next", 8'd10, 1'b0);
        tick();

        // Random traffic against the window model.
        win.delete();
        pend      = 1'b0;
        pend_data = '0;
        pend_sat  = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            chk("rnd_in_ready",  128'(bus.in_ready),  128'(!pend));
            chk("rnd_out_valid", 128'(bus.out_valid), 128'(pend));
            if (pend) begin
                chk("rnd_out_data", 128'(bus.out_data), 128'(pend_data));
                chk("rnd_out_sat",  128'(bus.out_sat),  128'(pend_sat));
            end

            r_iv   = ($urandom_range(0, 3) != 0);
            r_clr  = ($urandom_range(0, 63) == 0);
            r_ordy = ($urandom_range(0, 2) != 0);
            sel    = $urandom_range(0, 15);
            rbits  = {$urandom, $urandom, $urandom};
            if (sel == 0)      r_d = rbits[PW-1:0];
            else if (sel < 4)  r_d = PW'($urandom_range(0, 63));
            else               r_d = PW'($urandom_range(0, 1023));
            drive(r_iv, r_d, r_clr, r_ordy);

            if (r_clr) begin
                win.delete();
                pend     = 1'b0;
                pend_sat = 1'b0;
            end else if (pend) begin
                if (r_ordy) pend = 1'b0;
            end else if (r_iv) begin
                win.push_back(r_d);
                if (win.size() == int'(TAPS)) begin
                    wsum = '0;
                    foreach (win[k]) wsum = wsum + 128'(win[k]);
                    wshift = wsum / (128'(1) << SHIFT);
                    if (wshift > 128'(255)) begin
                        pend_data = 8'd255;
                        pend_sat  = 1'b1;
                    end else begin
                        pend_data = wshift[OW-1:0];
                        pend_sat  = 1'b0;
                    end
                    pend = 1'b1;
                    win.delete();
                end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/srcnn_mac_accum.md
# srcnn_mac_accum

Accumulation stage that sits directly downstream of the SRCNN unsigned product multiplier. It consumes a stream of unsigned 69-bit products and sums exactly `TAPS` consecutive products per convolution window. Each completed sum is rescaled by a fixed right shift, saturated to the output width, and emitted with a valid/ready handshake to the activation/write-back stage.

## Interface

**Parameters**
- `PROD_WIDTH`, 69: width of incoming unsigned product.
- `TAPS`, 81: products per window (9×9 kernel); legal range 1..1024.
- `ACC_WIDTH`, 79: accumulator width; must be ≥ `PROD_WIDTH + clog2(TAPS)`.
- `SHIFT`, 16: right shift applied to the final sum (fixed-point rescale).
- `OUT_WIDTH`, 32: width of the emitted result.

**Ports**
- `ap_clk` in 1: the single clock; all state updates on the rising edge.
- `ap_rst_n` in 1: reset, asynchronous and active-low.
- `in_data` in `PROD_WIDTH`: unsigned product from the multiplier.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: stage accepts a product this cycle.
- `clear` in 1: synchronous abort of the current window.
- `out_data` out `OUT_WIDTH`: saturated, shifted window sum.
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: consumer accepts `out_data`.
- `out_sat` out 1: the current `out_data` was saturated; qualified by `out_valid`.

## Operation

- **States.** `ACCUM` and `HOLD`; the block resets into `ACCUM`.
- **Reset values.** `acc` = 0, `cnt` = 0, `out_data` = 0, `out_valid` = 0, `out_sat` = 0.
- **`in_ready`** = (state == `ACCUM`). It is combinational from state only and never depends on `in_valid`.
- **Accept.** A transfer occurs on `in_valid && in_ready`.
  - If `cnt < TAPS-1`: `acc <= acc + in_data` (zero-extended), `cnt <= cnt + 1`.
  - If `cnt == TAPS-1` (last tap): `sum = acc + in_data`, `shifted = sum >> SHIFT` (logical).
  - `out_data <= shifted` if `shifted < 2^OUT_WIDTH`, else all ones.
  - `out_sat <=` (overflow occurred).
  - `out_valid <= 1`, `acc <= 0`, `cnt <= 0`, state → `HOLD`.
- **`HOLD` state.** `out_data` and `out_sat` are held stable. On `out_ready`: `out_valid <= 0`, state → `ACCUM`.
- **`clear`** (any state, highest priority after reset): `acc <= 0`, `cnt <= 0`, `out_valid <= 0`, `out_sat <= 0`, state → `ACCUM`.
  - The product offered in the same cycle is dropped.
  - A pending result in `HOLD` is discarded.
- **Arithmetic.** The accumulator never wraps, because `ACC_WIDTH` is sized for `TAPS × (2^PROD_WIDTH − 1)`. Saturation applies only at the output.
- **`TAPS` = 1.** Every accepted product goes directly to `HOLD`.
- **Async reset mid-window.** The partial sum is lost and no output is produced for that window.

## Timing

- **Latency.** 1 cycle from acceptance of the last tap to `out_valid` high.
- **Throughput.** One product per cycle within a window. There is at least 1 dead cycle per window: the `HOLD` state, plus any cycles spent waiting for `out_ready`.
- **Minimum window period.** `TAPS + 1` cycles.
- **Output stability.** `out_valid` is never deasserted without `out_ready` or `clear`. `out_data` is unchanged while `out_valid && !out_ready`.
- **Registered outputs.** `out_data`, `out_valid` and `out_sat` come straight from flops.
- **Critical path.** One `ACC_WIDTH`-bit adder plus shift/compare in the last-tap cycle. Retiming is not required at the target clock.

## Structure

- **Shared package `srcnn_pkg`:**
  - `PROD_WIDTH`, `OUT_WIDTH` and the `SHIFT` default.
  - The `acc_state_t` enum (`ACCUM`, `HOLD`).
  - A `clog2`-based width-check function; elaboration fails if `ACC_WIDTH` is too small.
- **Sub-module `srcnn_sat_shift`.** A combinational shift-and-saturate unit: `ACC_WIDTH` input, `OUT_WIDTH` output plus an overflow flag. It is reused by the bias/activation stage.
- **Top level.** Holds the FSM, tap counter, accumulator and output register.

## Test plan

Bench parameters: `TAPS` = 4, `SHIFT` = 2, `OUT_WIDTH` = 8, unless stated otherwise.

1. **Basic window.** Products 4, 8, 12, 16 back-to-back, `out_ready` = 1 → one cycle after the 4th, `out_valid` = 1, `out_data` = 10, `out_sat` = 0. `in_ready` is low for exactly 1 cycle.
2. **Saturation.** Four products of 400 → sum 1600, shifted 400 > 255 → `out_data` = 255, `out_sat` = 1.
3. **Backpressure.** Hold `out_ready` = 0 for 5 cycles after the result → `out_valid` and `out_data` stay stable and `in_ready` stays 0. Assert `out_ready` → `out_valid` drops next cycle and `in_ready` rises.
4. **Gaps in the input.** `in_valid` toggled every other cycle with products 1, 2, 3, 4 → `out_data` = 2; the window boundary is counted by accepts, not cycles.
5. **Clear mid-window.** Accept 100, 100, then `clear` together with `in_valid` (product 100) → that product is dropped. Next 4 products of 4 → `out_data` = 4.
6. **Async reset.** `ap_rst_n` low mid-window and again mid-`HOLD` → all outputs 0 immediately, state `ACCUM`. The next full window sums from zero.
